// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: shift op codes and controller state encodings.
// The op codes match the decode stage and the existing shift register datapath.
package shift_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the decode stage, the shift sequencer and the ALU operand path.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
// a source holds valid and its payload stable until that edge, and ready never depends on valid.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AMT_W-1:0] req_amt;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             busy;

  modport master (
    output req_valid, req_op, req_amt, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_op, req_amt, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, busy
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-bit shift step; also reused by decode-stage checkers.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_next,
  output logic             carry
);

  always_comb begin
    d_next = d;
    carry  = d[0];
    case (op)
      SH_LSL: begin
        carry  = d[WIDTH-1];
        d_next = {d[WIDTH-2:0], 1'b0};
      end
      SH_LSR:  d_next = {1'b0, d[WIDTH-1:1]};
      SH_ASR:  d_next = {d[WIDTH-1], d[WIDTH-1:1]};
      default: d_next = {d[0], d[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts one request, applies one single-bit step per cycle,
// then presents the result and last carry-out until the consumer takes it.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic                clk,
  input  logic                rst,
  shift_sequencer_if.slave    bus,
  output state_e              dbg_state
);

  state_e           state;
  shift_op_e        op_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic             carry_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             busy_q;

  logic [AMT_W-1:0] eff_amt;
  logic [WIDTH-1:0] step_d;
  logic             step_c;

  // Rotates wrap modulo WIDTH; the other ops saturate at WIDTH, which already empties the word.
  always_comb begin
    if (shift_op_e'(bus.req_op) == SH_ROR) begin
      eff_amt = bus.req_amt & AMT_W'(WIDTH - 1);
    end else if (bus.req_amt >= AMT_W'(WIDTH)) begin
      eff_amt = AMT_W'(WIDTH);
    end else begin
      eff_amt = bus.req_amt;
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .d      (data_q),
    .d_next (step_d),
    .carry  (step_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= SH_LSL;
      data_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            data_q      <= bus.req_data;
            op_q        <= shift_op_e'(bus.req_op);
            cnt_q       <= eff_amt;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          carry_q <= 1'b0;
          if (cnt_q != '0) begin
            state <= ST_SHIFT;
          end else begin
            rsp_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          data_q  <= step_d;
          carry_q <= step_c;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            rsp_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        default: begin
          // Data and carry are left untouched here so backpressure holds the response stable.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed corner cases plus random requests checked against an
// arithmetic model of the shift ops and the eff_amt+2 response latency.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = 5;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH:0] exp_q[$];   // {carry, data}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-word view of each op: shift a widened copy by the full amount at once.
  function automatic logic [WIDTH:0] model(input logic [1:0] op, input int amt, output int eff);
    logic [7:0]  d;
    logic [15:0] w;
    logic [7:0]  res;
    logic        c;
    d   = 8'h00;
    res = 8'h00;
    c   = 1'b0;
    eff = (op == 2'b11) ? (amt % WIDTH) : ((amt > WIDTH) ? WIDTH : amt);
    return {c, res};
  endfunction

  function automatic logic [WIDTH:0] ref_shift(input logic [1:0] op, input int amt,
                                               input logic [7:0] d, output int eff);
    logic [15:0] w;
    logic [7:0]  res;
    logic        c;
    logic [WIDTH:0] dummy;
    dummy = model(op, amt, eff);
    case (op)
      2'b00: begin w = {8'h00, d} << eff; res = w[7:0];  c = (eff == 0) ? 1'b0 : w[8]; end
      2'b01: begin w = {d, 8'h00} >> eff; res = w[15:8]; c = (eff == 0) ? 1'b0 : w[7]; end
      2'b10: begin
        w   = {{8{d[7]}}, d} >> eff;
        res = w[7:0];
        c   = (eff == 0) ? 1'b0 : d[(eff - 1 > 7) ? 7 : eff - 1];
      end
      default: begin w = {d, d} >> eff; res = w[7:0]; c = (eff == 0) ? 1'b0 : res[7]; end
    endcase
    return {c, res};
  endfunction

  // ---------------- driver tasks ----------------
  // Called on a negedge; issues one request, checks latency/result, applies `hold` cycles of backpressure.
  task automatic do_req(input logic [1:0] op, input logic [4:0] amt, input logic [7:0] data,
                        input int hold, input bit pulse);
    logic [WIDTH:0] exp;
    int eff, lat, n;
    exp = ref_shift(op, int'(amt), data, eff);
    bus.req_op    = op;
    bus.req_amt   = amt;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("accept_timeout", 32'(n < 50), 32'd1);
    if (n >= 50) begin bus.req_valid = 1'b0; return; end
    exp_q.push_back(exp);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 64) begin
      check_eq("req_ready_while_busy", 32'(bus.req_ready), 32'd0);
      check_eq("busy_flag", 32'(bus.busy), 32'd1);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    bus.rsp_ready = 1'b0;
    check_eq("rsp_timeout", 32'(lat < 64), 32'd1);
    if (lat >= 64) begin void'(exp_q.pop_front()); return; end
    exp = exp_q.pop_front();
    check_eq("latency", 32'(lat), 32'(eff + 2));
    check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp[7:0]));
    check_eq("rsp_carry", 32'(bus.rsp_carry), 32'(exp[8]));
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.req_valid = 1'b1;
        bus.req_data  = ~data;
        bus.req_amt   = 5'd1;
      end
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_data", 32'(bus.rsp_data), 32'(exp[7:0]));
      check_eq("hold_carry", 32'(bus.rsp_carry), 32'(exp[8]));
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("post_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 64) begin @(negedge clk); n++; end
    check_eq("rsp_timeout", 32'(n < 64), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH:0] exp;
    int eff, n;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_amt   = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Directed corners: plain shifts, clamping, rotate wrap, zero amount, backpressure.
    do_req(2'b00, 5'd1,  8'h81, 0, 1'b0);
    do_req(2'b01, 5'd4,  8'hF0, 0, 1'b0);
    do_req(2'b10, 5'd20, 8'h80, 0, 1'b0);
    do_req(2'b11, 5'd9,  8'h01, 0, 1'b0);
    do_req(2'b11, 5'd8,  8'h5A, 0, 1'b0);
    do_req(2'b00, 5'd0,  8'hA5, 0, 1'b0);
    do_req(2'b00, 5'd31, 8'h01, 0, 1'b0);
    do_req(2'b01, 5'd8,  8'h80, 0, 1'b0);
    do_req(2'b10, 5'd8,  8'h7F, 0, 1'b0);
    do_req(2'b01, 5'd3,  8'hB6, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_req(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a shift drops the request entirely.
    bus.req_op = 2'b00; bus.req_amt = 5'd7; bus.req_data = 8'hFF; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_in_shift", 32'(dbg_state), 32'(ST_SHIFT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("abort_req_ready", 32'(bus.req_ready), 32'd1);
    do_req(2'b01, 5'd7, 8'h80, 0, 1'b0);

    // Back-to-back: req_valid held, rsp_ready tied high.
    bus.rsp_ready = 1'b1;
    bus.req_op = 2'b01; bus.req_amt = 5'd2; bus.req_data = 8'hC3; bus.req_valid = 1'b1;
    exp_q.push_back(ref_shift(2'b01, 2, 8'hC3, eff));
    @(negedge clk);
    bus.req_op = 2'b00; bus.req_amt = 5'd3; bus.req_data = 8'h35;
    exp_q.push_back(ref_shift(2'b00, 3, 8'h35, eff));
    wait_rsp(n);
    exp = exp_q.pop_front();
    check_eq("b2b_first_data", 32'(bus.rsp_data), 32'(exp[7:0]));
    check_eq("b2b_first_carry", 32'(bus.rsp_carry), 32'(exp[8]));
    @(negedge clk);
    check_eq("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
    check_eq("b2b_idle_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("b2b_second_accept", 32'(dbg_state), 32'(ST_LOAD));
    wait_rsp(n);
    exp = exp_q.pop_front();
    check_eq("b2b_second_data", 32'(bus.rsp_data), 32'(exp[7:0]));
    check_eq("b2b_second_carry", 32'(bus.rsp_carry), 32'(exp[8]));
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("b2b_end_state", 32'(dbg_state), 32'(ST_IDLE));

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
